// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo up/down counter with load, wrap/saturate, tc pulse and sticky ovf.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module mod_updown_counter #(
    parameter int WIDTH      = 8,
    parameter int MODULUS    = 256,
    parameter int SATURATE   = 0,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  clr_flag,
    input  logic [PRESCALE_W-1:0] prescale_div,
    output logic [WIDTH-1:0]      out,
    output logic                  tc,
    output logic                  ovf
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    logic tick;
    logic at_bound;
    logic [WIDTH-1:0] load_clamped;
`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] div;
    // >= rather than == so a live decrease of prescale_div cannot strand the divider
    assign tick = div >= prescale_div;
    always_ff @(posedge clk) begin
        if (rst || load) div <= '0;
        else if (en) div <= tick ? '0 : div + 1'b1;
    end
`else
    logic unused_prescale;
    assign unused_prescale = &{1'b0, prescale_div};
    assign tick = 1'b1;
`endif
    assign at_bound     = up ? (out == MAX) : (out == '0);
    assign load_clamped = (load_val > MAX) ? MAX : load_val;
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (load) begin
            out <= load_clamped;
            tc  <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clr_flag) ovf <= 1'b0;
            if (en && tick) begin
                if (at_bound) begin
                    tc  <= 1'b1;
                    ovf <= 1'b1;
                    if (SATURATE == 0) out <= up ? '0 : MAX;
                end else begin
                    out <= up ? out + 1'b1 : out - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: scoreboard bench driving a wrapping and a saturating counter (MODULUS=10) in parallel.
module tb_mod_updown_counter;
    localparam int MOD = 10;
    logic clk = 1'b0;
    logic rst, en, up, load, clr_flag;
    logic [7:0] load_val;
    logic [3:0] prescale_div;
    logic [7:0] out_w, out_s;
    logic tc_w, tc_s, ovf_w, ovf_s;
    int errs = 0;
    int checks = 0;
    typedef struct {
        int  o;
        bit  t;
        bit  f;
    } exp_t;
    exp_t q[$];
    int  m_out[2];
    bit  m_tc[2];
    bit  m_ovf[2];
    int  m_div;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(8), .MODULUS(MOD), .SATURATE(0), .PRESCALE_W(4)) dut_w (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flag(clr_flag), .prescale_div(prescale_div), .out(out_w), .tc(tc_w), .ovf(ovf_w)
    );
    mod_updown_counter #(.WIDTH(8), .MODULUS(MOD), .SATURATE(1), .PRESCALE_W(4)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flag(clr_flag), .prescale_div(prescale_div), .out(out_s), .tc(tc_s), .ovf(ovf_s)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive one cycle, predict both counters, then compare after the edge.
    task automatic cyc(input string tag, input bit r, input bit l, input bit e, input bit u,
                       input bit c, input int lv, input int pd);
        bit t;
        exp_t x, y;
        rst = r; load = l; en = e; up = u; clr_flag = c;
        load_val = 8'(lv); prescale_div = 4'(pd);
`ifdef COUNTER_PRESCALE_EN
        t = m_div >= pd;
`else
        t = 1'b1;
`endif
        for (int s = 0; s < 2; s++) begin
            if (r) begin
                m_out[s] = 0; m_tc[s] = 0; m_ovf[s] = 0;
            end else if (l) begin
                m_out[s] = (lv > MOD - 1) ? MOD - 1 : lv; m_tc[s] = 0;
            end else begin
                m_tc[s] = 0;
                if (c) m_ovf[s] = 0;
                if (e && t) begin
                    if ((u && m_out[s] == MOD - 1) || (!u && m_out[s] == 0)) begin
                        m_tc[s] = 1; m_ovf[s] = 1;
                        if (s == 0) m_out[s] = (m_out[s] + (u ? 1 : MOD - 1)) % MOD;
                    end else begin
                        m_out[s] = m_out[s] + (u ? 1 : -1);
                    end
                end
            end
            q.push_back('{m_out[s], m_tc[s], m_ovf[s]});
        end
        if (r || l) m_div = 0;
        else if (e) m_div = t ? 0 : m_div + 1;
        @(posedge clk);
        #1;
        x = q.pop_front();
        y = q.pop_front();
        check({tag, ".w.out"}, int'(out_w), x.o);
        check({tag, ".w.tc"},  int'(tc_w),  int'(x.t));
        check({tag, ".w.ovf"}, int'(ovf_w), int'(x.f));
        check({tag, ".s.out"}, int'(out_s), y.o);
        check({tag, ".s.tc"},  int'(tc_s),  int'(y.t));
        check({tag, ".s.ovf"}, int'(ovf_s), int'(y.f));
    endtask

    initial begin
        m_out = '{0, 0}; m_tc = '{0, 0}; m_ovf = '{0, 0}; m_div = 0;
        rst = 1; load = 0; en = 0; up = 1; clr_flag = 0; load_val = 0; prescale_div = 0;
        cyc("rst0", 1, 0, 0, 1, 0, 0, 0);
        cyc("rst1", 1, 0, 0, 1, 0, 0, 0);
        check("reset_out", int'(out_w), 0);
        check("reset_ovf", int'(ovf_s), 0);
        for (int i = 0; i < 10; i++) cyc("t1_up", 0, 0, 1, 1, 0, 0, 0);
        check("t1_wrap_out", int'(out_w), 0);
        check("t1_wrap_tc", int'(tc_w), 1);
        check("t1_sat_hold", int'(out_s), 9);
        cyc("t1_after", 0, 0, 1, 1, 0, 0, 0);
        check("t1_ovf_sticky", int'(ovf_w), 1);
        cyc("t2_load", 0, 1, 0, 1, 0, 200, 0);
        check("t2_clamp", int'(out_w), 9);
        check("t2_tc", int'(tc_w), 0);
        cyc("t2_step", 0, 0, 1, 1, 0, 0, 0);
        check("t2_wrap", int'(out_w), 0);
        cyc("t3_load", 0, 1, 0, 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) cyc("t3_down", 0, 0, 1, 0, 0, 0, 0);
        check("t3_sat_out", int'(out_s), 0);
        check("t3_sat_tc", int'(tc_s), 1);
        check("t3_wrap_down", int'(out_w), 8);
        cyc("t4_clr", 0, 0, 0, 1, 1, 0, 0);
        check("t4_lone_clr", int'(ovf_w), 0);
        cyc("t4_load9", 0, 1, 0, 1, 0, 9, 0);
        cyc("t4_clr_wrap", 0, 0, 1, 1, 1, 0, 0);
        check("t4_set_wins", int'(ovf_w), 1);
        cyc("t4_clr2", 0, 0, 0, 1, 1, 0, 0);
        check("t4_cleared", int'(ovf_w), 0);
        cyc("t5_load_en", 0, 1, 1, 1, 0, 5, 0);
        check("t5_load_wins", int'(out_w), 5);
        cyc("t5_up", 0, 0, 1, 1, 0, 0, 0);
        cyc("t5_up", 0, 0, 1, 1, 0, 0, 0);
        check("t5_at7", int'(out_w), 7);
        cyc("t5_rst", 1, 1, 1, 1, 0, 3, 0);
        check("t5_rst_out", int'(out_w), 0);
`ifdef COUNTER_PRESCALE_EN
        for (int i = 0; i < 12; i++) cyc("t6_div3", 0, 0, 1, 1, 0, 0, 3);
        check("t6_div3_out", int'(out_w), 3);
        for (int i = 0; i < 4; i++) cyc("t6_div0", 0, 0, 1, 1, 0, 0, 0);
`endif
        for (int i = 0; i < 60; i++)
            cyc("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 5) == 0),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
